// File: rtl/switch_priority_capture_pkg.sv
// Shared types and helpers for the switch priority capture block.
// Holds the capture FSM state type and the output code-width function.
package spc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        ACTIVE = 2'd2
    } spc_state_e;

    // A single input still needs a 1-bit code.
    function automatic int spc_code_w(input int n_in);
        int w;
        w = $clog2(n_in);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/switch_priority_capture_sw_debounce.sv
// One switch bit: 2-flop synchroniser followed by a counter-based debouncer.
// The debounced level changes only after DB_CYCLES consecutive disagreeing samples.
module sw_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_in,
    output logic db_out
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = sw_in;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        // Any agreeing sample restarts the stability window.
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db_out = db_q;

endmodule

// File: rtl/switch_priority_capture.sv
// Debounces N_IN switches, priority-encodes the debounced vector and hands
// each new winning code to a ready/valid consumer, flagging dropped changes.
module switch_priority_capture
    import spc_pkg::*;
#(
    parameter int N_IN      = 10,
    parameter int DB_CYCLES = 16,
    parameter int LOW_WINS  = 0,
    localparam int CODE_W   = spc_code_w(N_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN-1:0]   sw_in,
    input  logic              out_ready,
    input  logic              clr_ovf,
    output logic              out_valid,
    output logic [CODE_W-1:0] out_code,
    output logic [CODE_W-1:0] code_now,
    output logic              any_active,
    output logic              ovf
);

    logic [N_IN-1:0] db_vec;

    for (genvar g = 0; g < N_IN; g++) begin : g_db
        sw_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .sw_in (sw_in[g]),
            .db_out(db_vec[g])
        );
    end

    // Scan from the losing end so the last hit is the winner.
    always_comb begin
        code_now = '0;
        for (int i = 0; i < N_IN; i++) begin
            int idx;
            idx = (LOW_WINS != 0) ? (N_IN - 1 - i) : i;
            if (db_vec[idx]) begin
                code_now = CODE_W'(idx);
            end
        end
    end

    assign any_active = |db_vec;

    spc_state_e        state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [CODE_W-1:0] out_code_q, out_code_d;
    logic [CODE_W-1:0] last_sent_q, last_sent_d;
    logic              ovf_q, ovf_d;
    logic              ovf_set;

    always_comb begin
        state_d     = state_q;
        out_code_d  = out_code_q;
        last_sent_d = last_sent_q;
        ovf_set     = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_active) begin
                    out_code_d = code_now;
                    state_d    = PEND;
                end
            end
            PEND: begin
                // The pending code is frozen; a competing change only raises ovf.
                if (any_active && (code_now != out_code_q)) begin
                    ovf_set = 1'b1;
                end
                if (out_valid_q && out_ready) begin
                    last_sent_d = out_code_q;
                    state_d     = any_active ? ACTIVE : IDLE;
                end
            end
            ACTIVE: begin
                if (!any_active) begin
                    state_d = IDLE;
                end else if (code_now != last_sent_q) begin
                    out_code_d = code_now;
                    state_d    = PEND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        out_valid_d = (state_d == PEND);
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            last_sent_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            last_sent_q <= last_sent_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_switch_priority_capture.sv
// Bench for switch_priority_capture: directed scenarios plus randomized
// switch activity compared every cycle against a behavioural model.
module tb_switch_priority_capture;

    localparam int N  = 10;
    localparam int DB = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  sw_in = '0;
    logic          out_ready = 1'b1;
    logic          clr_ovf = 1'b0;

    logic          out_valid, any_active, ovf;
    logic [CW-1:0] out_code, code_now;
    logic          lo_valid, lo_any, lo_ovf;
    logic [CW-1:0] lo_code, lo_code_now;

    switch_priority_capture #(.N_IN(N), .DB_CYCLES(DB), .LOW_WINS(0)) dut (
        .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .out_ready(out_ready),
        .clr_ovf(clr_ovf), .out_valid(out_valid), .out_code(out_code),
        .code_now(code_now), .any_active(any_active), .ovf(ovf)
    );

    switch_priority_capture #(.N_IN(N), .DB_CYCLES(DB), .LOW_WINS(1)) dut_lo (
        .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .out_ready(out_ready),
        .clr_ovf(clr_ovf), .out_valid(lo_valid), .out_code(lo_code),
        .code_now(lo_code_now), .any_active(lo_any), .ovf(lo_ovf)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference: input delay line, per-bit stability run, event handler.
    bit [N-1:0] m_s1, m_s2, m_db;
    int         m_run[N];
    int         m_mode;     // 0 waiting, 1 event offered, 2 event delivered
    int         m_code, m_last;
    bit         m_ovf;

    function automatic int enc(input bit [N-1:0] v, input bit low);
        if (low) begin
            for (int i = 0; i < N; i++) if (v[i]) return i;
        end else begin
            for (int i = N - 1; i >= 0; i--) if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
        m_mode = 0; m_code = 0; m_last = 0; m_ovf = 1'b0;
    endtask

    task automatic model_step();
        bit [N-1:0] db_old;
        int         cn;
        bit         any, set;
        db_old = m_db;
        cn     = enc(db_old, 1'b0);
        any    = |db_old;
        set    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_s2[i] != m_db[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DB) begin
                    m_db[i]  = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = sw_in;
        if (m_mode == 0) begin
            if (any) begin m_code = cn; m_mode = 1; end
        end else if (m_mode == 1) begin
            if (any && cn != m_code) set = 1'b1;
            if (out_ready) begin
                m_last = m_code;
                m_mode = any ? 2 : 0;
            end
        end else begin
            if (!any) m_mode = 0;
            else if (cn != m_last) begin m_code = cn; m_mode = 1; end
        end
        if (set) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
        chk("out_valid", out_valid, (m_mode == 1));
        chk("out_code", out_code, m_code);
        chk("code_now", code_now, enc(m_db, 1'b0));
        chk("any_active", any_active, |m_db);
        chk("ovf", ovf, m_ovf);
        chk("lo_code_now", lo_code_now, enc(m_db, 1'b1));
        chk("lo_any_active", lo_any, |m_db);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_code", out_code, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_lo_ovf", lo_ovf, 0);
        tick();
        tick();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        sw_in = '0; out_ready = 1'b1; clr_ovf = 1'b0;
        apply_reset();

        // Single press: event after 7 sampling edges, one-cycle pulse.
        sw_in = 10'h008;
        repeat (6) tick();
        chk("lat_pre_valid", out_valid, 0);
        tick();
        chk("lat_valid", out_valid, 1);
        chk("lat_code", out_code, 3);
        chk("lat_code_now", code_now, 3);
        chk("lat_any", any_active, 1);
        tick();
        chk("lat_pulse_end", out_valid, 0);

        // Two switches, both priority directions.
        apply_reset();
        sw_in = 10'h208;
        repeat (7) tick();
        chk("hi_valid", out_valid, 1);
        chk("hi_code", out_code, 9);
        chk("lo_valid", lo_valid, 1);
        chk("lo_code", lo_code, 3);

        // Glitch shorter than the debounce window.
        apply_reset();
        sw_in = 10'h020;
        repeat (3) tick();
        sw_in = '0;
        repeat (12) begin
            tick();
            chk("glitch_valid", out_valid, 0);
            chk("glitch_code_now", code_now, 0);
        end

        // Back-pressure: first event held, competing change flagged.
        apply_reset();
        out_ready = 1'b0;
        sw_in = 10'h004;
        repeat (7) tick();
        chk("bp_valid", out_valid, 1);
        chk("bp_code", out_code, 2);
        sw_in = 10'h084;
        repeat (10) tick();
        chk("bp_hold_code", out_code, 2);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_ovf", ovf, 1);
        out_ready = 1'b1;
        tick();
        chk("bp_accept", out_valid, 0);
        chk("bp_ovf_kept", ovf, 1);
        tick();
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_code", out_code, 7);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("bp_ovf_clr", ovf, 0);

        // Release returns to idle; re-press produces a fresh event.
        apply_reset();
        sw_in = 10'h010;
        repeat (7) tick();
        chk("rp_valid", out_valid, 1);
        chk("rp_code", out_code, 4);
        tick();
        sw_in = '0;
        repeat (8) tick();
        chk("rp_any_off", any_active, 0);
        chk("rp_valid_off", out_valid, 0);
        sw_in = 10'h010;
        repeat (6) tick();
        chk("rp_pre_valid", out_valid, 0);
        tick();
        chk("rp_again_valid", out_valid, 1);
        chk("rp_again_code", out_code, 4);

        // Reset during a pending event, switch held through release.
        apply_reset();
        out_ready = 1'b0;
        sw_in = 10'h002;
        repeat (8) tick();
        chk("ar_pend", out_valid, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar_async_valid", out_valid, 0);
        chk("ar_async_code", out_code, 0);
        chk("ar_async_any", any_active, 0);
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (6) tick();
        chk("ar_pre_valid", out_valid, 0);
        tick();
        chk("ar_valid", out_valid, 1);
        chk("ar_code", out_code, 1);

        // Randomized switch activity with random back-pressure and clears.
        apply_reset();
        for (int k = 0; k < 220; k++) begin
            int hold;
            case ($urandom_range(0, 3))
                0: sw_in = '0;
                1: sw_in = N'(1) << $urandom_range(0, N - 1);
                default: sw_in = N'($urandom);
            endcase
            hold = (($urandom_range(0, 4)) == 0) ? $urandom_range(1, DB) : $urandom_range(DB + 3, 16);
            repeat (hold) begin
                out_ready = ($urandom_range(0, 3) != 0);
                clr_ovf   = ($urandom_range(0, 15) == 0);
                tick();
            end
        end
        clr_ovf = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
